// File: rtl/adder_pkg.sv
// adder_pkg
// Shared definitions for the pipelined adder/subtractor slice:
//   OP_ADD / OP_SUB    - encodings of the per-beat 'sub' select
//   adder_chunk_w()    - carry-chain chunk width for a WIDTH/STAGES split
//   adder_sat_pos/neg  - clamp patterns (0x7F..F / 0x80..0) for a given width,
//                        returned right-aligned in an ADDER_MAX_W-bit vector
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest operand the clamp-pattern helpers can describe.
  localparam int ADDER_MAX_W = 1024;

  function automatic int adder_chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Largest positive two's-complement value of 'width' bits.
  function automatic logic [ADDER_MAX_W-1:0] adder_sat_pos(input int width);
    logic [ADDER_MAX_W-1:0] v;
    v = {ADDER_MAX_W{1'b0}};
    for (int i = 0; i < width - 1; i++) begin
      v[i] = 1'b1;
    end
    return v;
  endfunction

  // Most negative two's-complement value of 'width' bits.
  function automatic logic [ADDER_MAX_W-1:0] adder_sat_neg(input int width);
    logic [ADDER_MAX_W-1:0] v;
    v = {ADDER_MAX_W{1'b0}};
    v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// adder_chunk
// Combinational W-bit slice of the carry chain.
//   a, b        in  W  operand chunks (b already inverted for subtract)
//   cin         in  1  carry into bit 0 of the chunk
//   s           out W  chunk sum
//   cout        out 1  carry out of the chunk MSB
//   c_into_msb  out 1  carry into the chunk MSB (used for signed overflow)
module adder_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_into_msb
);

  logic [W:0] full_s;

  assign full_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign s      = full_s[W-1:0];
  assign cout   = full_s[W];
  // The MSB sum bit is a^b^c_in, so the carry into it falls out by XOR.
  assign c_into_msb = full_s[W-1] ^ a[W-1] ^ b[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder
// Pipelined two's-complement adder/subtractor with a valid/ready stream.
// The carry chain is cut into STAGES chunks, one chunk per register stage,
// followed by a flag stage that registers sum/carryout/overflow/zero.
// Latency is STAGES cycles from the accepting edge to out_valid.
// Optional build macro: ADDER_SATURATE_EN clamps the sum on signed overflow.
//   clk, reset           clock, synchronous active-high reset
//   in_valid / in_ready  operand beat handshake (a, b, sub)
//   out_valid / out_ready result beat handshake (sum, carryout, overflow, zero)
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int CHUNK = adder_chunk_w(WIDTH, STAGES);

`ifdef ADDER_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(adder_sat_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(adder_sat_neg(WIDTH));
`endif

  logic advance_s;

  // Per-stage registers: operands skewed forward, partial sum, chunk carry.
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [WIDTH-1:0]  op_a_q  [STAGES];
  logic [WIDTH-1:0]  op_b_q  [STAGES];
  logic [WIDTH-1:0]  part_q  [STAGES];
  logic              carry_q [STAGES];
  logic              cmsb_q;

  // Per-stage next-state values.
  logic [WIDTH-1:0]  a_d       [STAGES];
  logic [WIDTH-1:0]  b_d       [STAGES];
  logic [WIDTH-1:0]  part_in_s [STAGES];
  logic [WIDTH-1:0]  part_d    [STAGES];
  logic              cin_s     [STAGES];
  logic              carry_d   [STAGES];
  logic              cmsb_s    [STAGES];
  logic [CHUNK-1:0]  chunk_s   [STAGES];

  // Flag stage.
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             carryout_q;
  logic             overflow_q;
  logic             zero_q;
  logic [WIDTH-1:0] raw_sum_s;
  logic [WIDTH-1:0] sum_d;
  logic             overflow_d;
  logic             zero_d;

  // Every stage moves together; a stalled output freezes the whole pipe.
  assign advance_s = ~out_valid_q | out_ready;
  assign in_ready  = advance_s & ~reset;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      // Subtract is A + ~B + 1: invert B once here and feed sub as carry-in.
      assign a_d[k]       = a;
      assign b_d[k]       = (sub == OP_SUB) ? ~b : b;
      assign cin_s[k]     = (sub == OP_SUB) ? 1'b1 : 1'b0;
      assign part_in_s[k] = {WIDTH{1'b0}};
    end else begin : g_rest
      assign a_d[k]       = op_a_q[k-1];
      assign b_d[k]       = op_b_q[k-1];
      assign cin_s[k]     = carry_q[k-1];
      assign part_in_s[k] = part_q[k-1];
    end

    adder_chunk #(.W(CHUNK)) u_chunk (
      .a          (a_d[k][k*CHUNK +: CHUNK]),
      .b          (b_d[k][k*CHUNK +: CHUNK]),
      .cin        (cin_s[k]),
      .s          (chunk_s[k]),
      .cout       (carry_d[k]),
      .c_into_msb (cmsb_s[k])
    );

    // Upper chunks of the partial sum are still zero, so OR merges cleanly.
    assign part_d[k] = part_in_s[k] | (WIDTH'(chunk_s[k]) << (k * CHUNK));
  end

  // Valid chain: stage 0 takes in_valid, each later stage its predecessor.
  always_comb begin
    valid_d    = {STAGES{1'b0}};
    valid_d[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
    end
  end

  // Flag stage inputs: overflow, optional clamp and zero on the final sum.
  always_comb begin
    raw_sum_s  = part_q[STAGES-1];
    overflow_d = carry_q[STAGES-1] ^ cmsb_q;
    sum_d      = raw_sum_s;
`ifdef ADDER_SATURATE_EN
    // The sign of A gives the direction of the true (unrepresentable) result.
    if (overflow_d) begin
      if (op_a_q[STAGES-1][WIDTH-1]) begin
        sum_d = SAT_NEG;
      end else begin
        sum_d = SAT_POS;
      end
    end else begin
      sum_d = raw_sum_s;
    end
`endif
    zero_d = (sum_d == {WIDTH{1'b0}});
  end

  // Pipeline and output registers, shifted in lock-step on advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= {STAGES{1'b0}};
      cmsb_q      <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        op_a_q[k]  <= {WIDTH{1'b0}};
        op_b_q[k]  <= {WIDTH{1'b0}};
        part_q[k]  <= {WIDTH{1'b0}};
        carry_q[k] <= 1'b0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= {WIDTH{1'b0}};
      carryout_q  <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else if (advance_s) begin
      valid_q <= valid_d;
      cmsb_q  <= cmsb_s[STAGES-1];
      for (int k = 0; k < STAGES; k++) begin
        op_a_q[k]  <= a_d[k];
        op_b_q[k]  <= b_d[k];
        part_q[k]  <= part_d[k];
        carry_q[k] <= carry_d[k];
      end
      out_valid_q <= valid_q[STAGES-1];
      if (valid_q[STAGES-1]) begin
        sum_q      <= sum_d;
        carryout_q <= carry_q[STAGES-1];
        overflow_q <= overflow_d;
        zero_q     <= zero_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carryout  = carryout_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule
